// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   ID/EX pipeline register. Captures the decoded operands, register indices
//   and control bits from ID and presents them to EX one cycle later. Detects
//   load-use hazards against the instruction currently in EX and requests a
//   one-cycle front-end stall while a bubble is inserted. Honours external
//   hold (sig_stall) and squash (sig_flush) requests and keeps a saturating
//   count of inserted bubbles.
//
// Ports
//   clk, reset             clock (rising edge), async active-high reset
//   sig_stall, sig_flush   external hold / squash requests
//   id_*                   decoded instruction fields from ID
//   ex_*                   registered copies of every id_* field
//   sig_hazard_stall       combinational load-use stall to PC and IF/ID
//   bubble_count           saturating count of bubbles inserted
module id_ex_pipe_reg #(
  parameter int size     = 32,
  parameter int reg_bits = 5,
  parameter int cnt_bits = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sig_stall,
  input  logic                sig_flush,
  input  logic                id_valid,
  input  logic [reg_bits-1:0] id_rs,
  input  logic [reg_bits-1:0] id_rt,
  input  logic [reg_bits-1:0] id_rd,
  input  logic                id_uses_rt,
  input  logic [size-1:0]     id_data_rs,
  input  logic [size-1:0]     id_data_rt,
  input  logic [size-1:0]     id_imm,
  input  logic                id_sig_alu_src,
  input  logic                id_sig_mem_read,
  input  logic                id_sig_mem_write,
  input  logic                id_sig_reg_write,
  input  logic [3:0]          id_alu_op,
  output logic                ex_valid,
  output logic [reg_bits-1:0] ex_rs,
  output logic [reg_bits-1:0] ex_rt,
  output logic [reg_bits-1:0] ex_rd,
  output logic                ex_uses_rt,
  output logic [size-1:0]     ex_data_rs,
  output logic [size-1:0]     ex_data_rt,
  output logic [size-1:0]     ex_imm,
  output logic                ex_sig_alu_src,
  output logic                ex_sig_mem_read,
  output logic                ex_sig_mem_write,
  output logic                ex_sig_reg_write,
  output logic [3:0]          ex_alu_op,
  output logic                sig_hazard_stall,
  output logic [cnt_bits-1:0] bubble_count
);

  logic load_use;
  logic bubble;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [cnt_bits-1:0] sat_inc(input logic [cnt_bits-1:0] v);
    return (&v) ? v : v + cnt_bits'(1);
  endfunction

  // A bubble in EX has ex_valid = 0, so it can never raise a hazard itself.
  // Index 0 is the hard-wired zero register and never creates a dependency.
  always_comb begin
    load_use = ex_valid & ex_sig_mem_read & (ex_rd != '0) & id_valid &
               ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  end

  // An external hold or squash takes priority, so the front-end stall is
  // masked; the hazard re-evaluates once the hold releases.
  assign sig_hazard_stall = load_use & ~sig_flush & ~sig_stall;

  // Flush beats stall; stall beats load-use.
  assign bubble = sig_flush | (~sig_stall & load_use);

  // ID -> EX register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid         <= 1'b0;
      ex_rs            <= '0;
      ex_rt            <= '0;
      ex_rd            <= '0;
      ex_uses_rt       <= 1'b0;
      ex_data_rs       <= '0;
      ex_data_rt       <= '0;
      ex_imm           <= '0;
      ex_sig_alu_src   <= 1'b0;
      ex_sig_mem_read  <= 1'b0;
      ex_sig_mem_write <= 1'b0;
      ex_sig_reg_write <= 1'b0;
      ex_alu_op        <= '0;
      bubble_count     <= '0;
    end else if (bubble) begin
      ex_valid         <= 1'b0;
      ex_rs            <= '0;
      ex_rt            <= '0;
      ex_rd            <= '0;
      ex_uses_rt       <= 1'b0;
      ex_data_rs       <= '0;
      ex_data_rt       <= '0;
      ex_imm           <= '0;
      ex_sig_alu_src   <= 1'b0;
      ex_sig_mem_read  <= 1'b0;
      ex_sig_mem_write <= 1'b0;
      ex_sig_reg_write <= 1'b0;
      ex_alu_op        <= '0;
      bubble_count     <= sat_inc(bubble_count);
    end else if (!sig_stall) begin
      ex_valid         <= id_valid;
      ex_rs            <= id_rs;
      ex_rt            <= id_rt;
      ex_rd            <= id_rd;
      ex_uses_rt       <= id_uses_rt;
      ex_data_rs       <= id_data_rs;
      ex_data_rt       <= id_data_rt;
      ex_imm           <= id_imm;
      ex_sig_alu_src   <= id_sig_alu_src;
      ex_sig_mem_read  <= id_sig_mem_read;
      ex_sig_mem_write <= id_sig_mem_write;
      ex_sig_reg_write <= id_sig_reg_write;
      ex_alu_op        <= id_alu_op;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  localparam int ACT_LOAD = 0;
  localparam int ACT_BUB  = 1;
  localparam int ACT_HOLD = 2;
  localparam int NV       = 23;

  logic        clk = 1'b0;
  logic        reset;
  logic        sig_stall, sig_flush;
  logic        id_valid, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_data_rs, id_data_rt, id_imm;
  logic        id_sig_alu_src, id_sig_mem_read, id_sig_mem_write, id_sig_reg_write;
  logic [3:0]  id_alu_op;
  logic        ex_valid, ex_uses_rt;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_data_rs, ex_data_rt, ex_imm;
  logic        ex_sig_alu_src, ex_sig_mem_read, ex_sig_mem_write, ex_sig_reg_write;
  logic [3:0]  ex_alu_op;
  logic        sig_hazard_stall;
  logic [3:0]  bubble_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.size(32), .reg_bits(5), .cnt_bits(4)) dut (
    .clk(clk), .reset(reset), .sig_stall(sig_stall), .sig_flush(sig_flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_data_rs(id_data_rs), .id_data_rt(id_data_rt),
    .id_imm(id_imm), .id_sig_alu_src(id_sig_alu_src),
    .id_sig_mem_read(id_sig_mem_read), .id_sig_mem_write(id_sig_mem_write),
    .id_sig_reg_write(id_sig_reg_write), .id_alu_op(id_alu_op),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_uses_rt(ex_uses_rt), .ex_data_rs(ex_data_rs), .ex_data_rt(ex_data_rt),
    .ex_imm(ex_imm), .ex_sig_alu_src(ex_sig_alu_src),
    .ex_sig_mem_read(ex_sig_mem_read), .ex_sig_mem_write(ex_sig_mem_write),
    .ex_sig_reg_write(ex_sig_reg_write), .ex_alu_op(ex_alu_op),
    .sig_hazard_stall(sig_hazard_stall), .bubble_count(bubble_count)
  );

  typedef struct {
    logic        flush, stall, valid;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt, mem_read, reg_write;
    logic [31:0] data_rs, imm;
    logic        haz;
    int          act;
    int          cnt;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic fl, st, v, input logic [4:0] rs, rt, rd,
                              input logic ur, mr, rw, input logic [31:0] drs, im,
                              input logic hz, input int act, cnt);
    vec_t r;
    r.flush = fl; r.stall = st; r.valid = v; r.rs = rs; r.rt = rt; r.rd = rd;
    r.uses_rt = ur; r.mem_read = mr; r.reg_write = rw; r.data_rs = drs; r.imm = im;
    r.haz = hz; r.act = act; r.cnt = cnt;
    return r;
  endfunction

  function automatic logic [120:0] id_bundle();
    return {id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_data_rs, id_data_rt, id_imm,
            id_sig_alu_src, id_sig_mem_read, id_sig_mem_write, id_sig_reg_write, id_alu_op};
  endfunction

  function automatic logic [120:0] ex_bundle();
    return {ex_valid, ex_rs, ex_rt, ex_rd, ex_uses_rt, ex_data_rs, ex_data_rt, ex_imm,
            ex_sig_alu_src, ex_sig_mem_read, ex_sig_mem_write, ex_sig_reg_write, ex_alu_op};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    sig_flush        = r.flush;
    sig_stall        = r.stall;
    id_valid         = r.valid;
    id_rs            = r.rs;
    id_rt            = r.rt;
    id_rd            = r.rd;
    id_uses_rt       = r.uses_rt;
    id_data_rs       = r.data_rs;
    id_data_rt       = ~r.data_rs;
    id_imm           = r.imm;
    id_sig_alu_src   = (r.imm != 32'h0);
    id_sig_mem_read  = r.mem_read;
    id_sig_mem_write = r.valid & ~r.reg_write & ~r.mem_read;
    id_sig_reg_write = r.reg_write;
    id_alu_op        = r.rd[3:0];
  endtask

  logic [120:0] exp_ex;
  vec_t         idle;

  initial begin
    //              fl st v  rs rt rd  ur mr rw data_rs       imm          hz act       cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        32'h0,        0, ACT_LOAD, 0);
    tbl[1]  = mk(0, 0, 1, 1, 2, 7,  0, 0, 1, 32'hDEADBEEF, 32'h10,       0, ACT_LOAD, 0);
    tbl[2]  = mk(0, 0, 1, 3, 4, 5,  1, 1, 1, 32'h100,      32'h8,        0, ACT_LOAD, 0);
    tbl[3]  = mk(0, 0, 1, 6, 5, 9,  1, 0, 1, 32'h33,       32'h0,        1, ACT_BUB,  1);
    tbl[4]  = mk(0, 0, 1, 6, 5, 9,  1, 0, 1, 32'h33,       32'h0,        0, ACT_LOAD, 1);
    tbl[5]  = mk(0, 0, 1, 1, 2, 5,  0, 1, 1, 32'h44,       32'h4,        0, ACT_LOAD, 1);
    tbl[6]  = mk(0, 0, 1, 6, 5, 10, 0, 0, 0, 32'h55,       32'h0,        0, ACT_LOAD, 1);
    tbl[7]  = mk(0, 0, 1, 2, 3, 0,  0, 1, 1, 32'h66,       32'h0,        0, ACT_LOAD, 1);
    tbl[8]  = mk(0, 0, 1, 0, 0, 11, 1, 0, 1, 32'h77,       32'h0,        0, ACT_LOAD, 1);
    tbl[9]  = mk(0, 0, 1, 4, 4, 5,  1, 1, 1, 32'h88,       32'hC,        0, ACT_LOAD, 1);
    tbl[10] = mk(0, 1, 1, 5, 1, 12, 0, 0, 1, 32'h99,       32'h0,        0, ACT_HOLD, 1);
    tbl[11] = mk(0, 1, 1, 5, 1, 12, 0, 0, 1, 32'h99,       32'h0,        0, ACT_HOLD, 1);
    tbl[12] = mk(0, 0, 1, 5, 1, 12, 0, 0, 1, 32'h99,       32'h0,        1, ACT_BUB,  2);
    tbl[13] = mk(0, 0, 1, 5, 1, 12, 0, 0, 1, 32'h99,       32'h0,        0, ACT_LOAD, 2);
    tbl[14] = mk(1, 1, 1, 7, 8, 13, 1, 0, 1, 32'hAA,       32'h2,        0, ACT_BUB,  3);
    tbl[15] = mk(0, 0, 1, 9, 10, 14, 1, 0, 1, 32'hCAFEF00D, 32'h7F,      0, ACT_LOAD, 3);
    tbl[16] = mk(0, 1, 1, 1, 1, 1,  1, 1, 1, 32'h1,        32'h1,        0, ACT_HOLD, 3);
    tbl[17] = mk(0, 1, 0, 2, 2, 2,  0, 0, 0, 32'h0,        32'h0,        0, ACT_HOLD, 3);
    tbl[18] = mk(0, 1, 1, 3, 3, 3,  0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, ACT_HOLD, 3);
    tbl[19] = mk(1, 0, 1, 4, 4, 4,  0, 0, 1, 32'h12,       32'h0,        0, ACT_BUB,  4);
    tbl[20] = mk(0, 0, 1, 1, 2, 5,  0, 1, 1, 32'h13,       32'h0,        0, ACT_LOAD, 4);
    tbl[21] = mk(1, 0, 1, 5, 5, 6,  1, 0, 1, 32'h14,       32'h0,        0, ACT_BUB,  5);
    tbl[22] = mk(0, 0, 1, 5, 5, 6,  1, 0, 1, 32'h14,       32'h0,        0, ACT_LOAD, 5);
    idle    = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,        32'h0,        0, ACT_LOAD, 0);

    // Reset asserted between edges: outputs must already read zero.
    drive(idle);
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("reset_ex", 128'(ex_bundle()), 128'h0);
    chk("reset_cnt", 128'(bubble_count), 128'h0);
    chk("reset_haz", 128'(sig_hazard_stall), 128'h0);
    @(negedge clk);
    reset  = 1'b0;
    exp_ex = '0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("haz_v%0d", i), 128'(sig_hazard_stall), 128'(tbl[i].haz));
      if (tbl[i].act == ACT_LOAD)     exp_ex = id_bundle();
      else if (tbl[i].act == ACT_BUB) exp_ex = '0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("ex_v%0d", i), 128'(ex_bundle()), 128'(exp_ex));
      chk($sformatf("cnt_v%0d", i), 128'(bubble_count), 128'(tbl[i].cnt));
    end

    // Mid-operation asynchronous reset clears outputs before the next edge.
    chk("pre_areset_valid", 128'(ex_valid), 128'h1);
    #2 reset = 1'b1;
    #1;
    chk("areset_ex", 128'(ex_bundle()), 128'h0);
    chk("areset_cnt", 128'(bubble_count), 128'h0);
    chk("areset_haz", 128'(sig_hazard_stall), 128'h0);
    reset = 1'b0;
    @(negedge clk);

    // Saturation: 20 consecutive flushes on a 4-bit counter stop at 15.
    drive(idle);
    sig_flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 13) chk("sat_cnt14", 128'(bubble_count), 128'd14);
      if (i == 14) chk("sat_cnt15", 128'(bubble_count), 128'd15);
    end
    chk("sat_final", 128'(bubble_count), 128'd15);
    chk("sat_ex", 128'(ex_bundle()), 128'h0);
    sig_flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Pipeline register between the decode (ID) and execute (EX) stages. It captures decoded operands, register indices and control bits, and presents them to the EX-stage operand-select multiplexers and ALU. It detects load-use hazards and requests a one-cycle front-end stall while it inserts a bubble. It also honours external stall (hold) and flush (bubble) requests and counts bubbles inserted.

## Interface
Parameters:
- `size`, 32, data/immediate width
- `reg_bits`, 5, register-index width
- `cnt_bits`, 16, bubble-counter width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `sig_stall`  in  1  external hold request from a later stage
- `sig_flush`  in  1  branch/exception squash; loads a bubble
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  `reg_bits` each  source/dest indices
- `id_uses_rt`  in  1  instruction reads `rt` as a source
- `id_data_rs`, `id_data_rt`, `id_imm`  in  `size` each  operand values
- `id_sig_alu_src`  in  1  1 = immediate operand
- `id_sig_mem_read`, `id_sig_mem_write`, `id_sig_reg_write`  in  1 each  memory and writeback controls
- `id_alu_op`  in  4  ALU operation code
- `ex_*`  out  same widths  registered copies of every `id_*` input, including `ex_valid`
- `sig_hazard_stall`  out  1  combinational load-use stall to the PC and IF/ID registers
- `bubble_count`  out  `cnt_bits`  saturating count of bubbles inserted

## Operation
- Load-use detect is combinational: `load_use = ex_valid & ex_sig_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)))`.
- `sig_hazard_stall = load_use & ~sig_flush & ~sig_stall`.
- Per-edge action, first match wins:
  1. `reset`: bubble. Counter = 0.
  2. `sig_flush`: bubble.
  3. `sig_stall`: hold all `ex_*` unchanged.
  4. `load_use`: bubble.
  5. Otherwise: load all `id_*` into `ex_*`.
- Bubble definition:
  - `ex_valid`, `ex_sig_mem_read`, `ex_sig_mem_write`, `ex_sig_reg_write`, `ex_sig_alu_src` = 0.
  - `ex_alu_op` = 0.
  - All index and data fields = 0.
- Counter behaviour:
  - `bubble_count` increments on each edge taking action 2 or 4.
  - Saturates at `2^cnt_bits-1`, no wrap.
  - Holds on actions 3 and 5.
- A bubble in EX never triggers `load_use`, because `ex_valid` = 0.
- Index 0 never creates a hazard.

## Timing
- Latency: one cycle from ID inputs to `ex_*`.
- Reset values: all outputs 0, including `sig_hazard_stall`, since `ex_valid` = 0.
- Reset is asynchronous. Assertion mid-operation clears outputs immediately, not at the next edge.
- Load-use sequence:
  - Cycle N: the load is in EX and the dependent instruction is in ID; `sig_hazard_stall` = 1.
  - Edge N+1: a bubble enters EX, and ID is held by the front end.
  - Cycle N+1: `sig_hazard_stall` = 0, because EX holds a bubble.
  - Edge N+2: the dependent instruction loads.
- Simultaneous `sig_flush` and `sig_stall`: flush wins; bubble and count increment.
- Simultaneous `sig_stall` and `load_use`: hold with no increment; `sig_hazard_stall` = 0. The hazard re-evaluates after the stall releases.
- No combinational path from `id_*` to `ex_*`. The only combinational output is `sig_hazard_stall`.

## Test plan
- Reset then idle:
  - Stimulus: assert `reset` between edges.
  - Required: all outputs read 0 before the next edge.
  - Required: with `id_valid=0` and no stall/flush, `ex_valid` stays 0 and `bubble_count` = 0.
- Plain transfer:
  - Stimulus: `id_data_rs=0xDEADBEEF`, `id_imm=0x10`, `id_rd=7`, `id_sig_reg_write=1`.
  - Required: those exact values appear on `ex_*` one edge later, with `ex_valid=1`.
- Load-use on `rt`:
  - Stimulus: a load with `rd=5` in EX; ID instruction has `rt=5` and `id_uses_rt=1`.
  - Required: `sig_hazard_stall=1`, next edge `ex_valid=0`, and `bubble_count` = 1.
  - Required: with `id_uses_rt=0` there is no stall.
  - Required: with `rd=0` there is no stall.
- Flush versus stall:
  - Stimulus: assert `sig_flush` and `sig_stall` together.
  - Required: bubble and count increment.
  - Stimulus: assert `sig_stall` alone for 3 cycles.
  - Required: `ex_*` constant and count unchanged.
- Stall masks hazard:
  - Stimulus: hold the load-use condition while `sig_stall=1`.
  - Required: `sig_hazard_stall=0` and `ex_*` held.
  - Required: after stall release, `sig_hazard_stall=1` and a bubble is inserted.
- Saturation:
  - Stimulus: `cnt_bits=4`, then 20 flushes.
  - Required: `bubble_count` stops at 15.
